array_or_merge_pipe: RTL and testbench
======================================

Name: array_or_merge_pipe

Overview:
- Parametrised next generation of the wired-OR multi-dimensional array bundle blocks; generalised in channel count, array shape and word width.
- Accepts CH channels of a ROWS x COLS array of W-bit words per transfer and resolves them with a bitwise OR across unmasked channels, giving wor-style net resolution.
- Results go through a 2-entry output buffer with valid/ready handshakes on both sides.
- Adds a replay mode that re-emits the last delivered array, the registered equivalent of a self-loop net.

Parameters:
- CH, 4: number of input channels (>=1).
- ROWS, 2: outer array dimension (>=1).
- COLS, 3: inner array dimension (>=1).
- W, 3: bits per array word (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transfer offered.
- in_ready  output  1  block can accept.
- in_data  input  [CH][ROWS][COLS][W]  per-channel arrays.
- ch_mask  input  CH  1 = channel contributes to OR; sampled with the transfer.
- replay  input  1  request replay mode.
- out_valid  output  1  output array available.
- out_ready  input  1  consumer accepts.
- out_data  output  [ROWS][COLS][W]  merged array.
- out_zero  output  1  out_data is all zeros; meaningful only while out_valid.
- fill  output  2  buffer occupancy, 0..2.

Behaviour:
- Transfers: input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Merge: merged[r][c] = OR over ch of (ch_mask[ch] ? in_data[ch][r][c] : 0). If ch_mask is all zero, the result is an all-zero array (supply0 semantics). The merge is computed combinationally and written into the buffer on the input transfer.
- Buffer: 2-entry FIFO.
  - Latency: data accepted in cycle N appears on out_data with out_valid=1 in cycle N+1, provided the buffer was empty.
  - Simultaneous push and pop leave fill unchanged and keep order.
- State machine:
  - EMPTY_HIST: no output transfer has occurred since reset.
  - STREAM: normal operation.
  - REPLAY: replay active.
  - EMPTY_HIST -> STREAM on the first output transfer.
  - STREAM -> REPLAY when replay=1 and the buffer is empty (fill==0). While replay=1 with fill>0, the block keeps draining in STREAM.
  - REPLAY -> STREAM when replay=0, evaluated each cycle.
  - replay=1 in EMPTY_HIST has no effect; the block streams normally.
- REPLAY outputs:
  - in_ready=0.
  - out_valid=1.
  - out_data = last delivered array, held in a replay register updated on every output transfer.
  - Each out_ready pulse counts as a transfer but does not change data.
- in_ready = (fill<2 || out_ready) && state!=REPLAY && !(replay && fill==0 && state!=EMPTY_HIST). In words, no new input is accepted in the cycle the block enters REPLAY.
- out_zero = (out_data == 0) whenever out_valid.
- Reset values (any cycle, including mid-transfer):
  - fill=0, out_valid=0, out_data=0, out_zero=0, in_ready=0 during rst, state=EMPTY_HIST, replay register=0.
  - Buffer contents are discarded.
- After reset: in_ready=1 in the first cycle after rst deasserts.

Optional Feature:
- Macro: ARRAY_OR_MERGE_STATS_EN.
- When defined, adds outputs:
  - stat_in_cnt (16 bits): counts input transfers.
  - stat_replay_cnt (16 bits): counts output transfers made in REPLAY.
  - stat_zero_cnt (16 bits): counts output transfers with out_zero=1.
- Counters wrap at 2^16 (0xFFFF+1 -> 0) and are cleared by rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package array_or_merge_pkg holds:
  - word_t as typedef logic [W-1:0], parameterised via package localparams with matching defaults.
  - state enum {EMPTY_HIST, STREAM, REPLAY} as 2-bit.
  - The FIFO depth localparam, set to 2.
- One natural sub-module: array_or_reduce, the combinational masked OR over CH channels. It is instantiated once; the FIFO and FSM stay in the top module.

Test Plan:
- Reset then push: CH=4, in_data[0][0][0]=3'b001, [2][0][0]=3'b100, ch_mask=4'b0101, out_ready=1 -> next cycle out_valid=1, out_data[0][0]=3'b101, fill=1 then 0.
- Masked zero: ch_mask=0 with nonzero data -> out_data all 0, out_zero=1.
- Backpressure: out_ready=0, three pushes -> fill=2, in_ready=0 on the third; raise out_ready -> outputs arrive in order, the third accepted the same cycle the first pops.
- Replay: deliver array A, set replay=1 with fill=0 -> in_ready=0, out_valid=1, out_data=A for 5 consecutive out_ready pulses; drop replay -> STREAM, in_ready=1.
- Replay from empty history: replay=1 right after reset -> no out_valid, in_ready=1, normal streaming.
- Reset mid-operation: fill=2, assert rst for 1 cycle -> fill=0, out_valid=0, stats (when ARRAY_OR_MERGE_STATS_EN defined) = 0; stat_in_cnt wraps 0xFFFF -> 0 after 65536 pushes.

Source files
------------

// File: rtl/array_or_merge_pkg.sv
// Shared types and default sizes for the wired-OR array merge pipeline.
// Optional statistics counters are enabled with ARRAY_OR_MERGE_STATS_EN.
package array_or_merge_pkg;

   localparam int DEF_CH     = 4;
   localparam int DEF_ROWS   = 2;
   localparam int DEF_COLS   = 3;
   localparam int DEF_W      = 3;
   localparam int FIFO_DEPTH = 2;

   typedef logic [DEF_W-1:0] word_t;

   typedef enum logic [1:0] {
      EMPTY_HIST,
      STREAM,
      REPLAY
   } state_e;

endpackage

// File: rtl/array_or_reduce.sv
// Combinational masked bitwise OR of CH channel arrays (wor-style resolution).
// An all-zero mask resolves to an all-zero array.
module array_or_reduce
   import array_or_merge_pkg::*;
#(
   parameter int CH   = DEF_CH,
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int W    = DEF_W
) (
   input  logic [CH-1:0][ROWS-1:0][COLS-1:0][W-1:0] in_data_i,
   input  logic [CH-1:0]                            ch_mask_i,
   output logic [ROWS-1:0][COLS-1:0][W-1:0]         merged_o
);

   always_comb begin
      // NOTE: default assigned first so every path drives merged_o and no latch is inferred.
      merged_o = '0;
      for (int ch = 0; ch < CH; ch++) begin
         if (ch_mask_i[ch]) begin
            merged_o = merged_o | in_data_i[ch];
         end
      end
   end

endmodule

// File: rtl/array_or_merge_pipe.sv
// Masked OR merge of CH arrays into a 2-entry valid/ready FIFO, with a replay
// mode re-emitting the last delivered array. Stats ports: ARRAY_OR_MERGE_STATS_EN.
module array_or_merge_pipe
   import array_or_merge_pkg::*;
#(
   parameter int CH   = DEF_CH,
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int W    = DEF_W
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [CH-1:0][ROWS-1:0][COLS-1:0][W-1:0] in_data,
   input  logic [CH-1:0]                            ch_mask,
   input  logic                                     replay,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [ROWS-1:0][COLS-1:0][W-1:0]         out_data,
   output logic                                     out_zero,
   output logic [1:0]                               fill
`ifdef ARRAY_OR_MERGE_STATS_EN
   ,
   output logic [15:0]                              stat_in_cnt,
   output logic [15:0]                              stat_replay_cnt,
   output logic [15:0]                              stat_zero_cnt
`endif
);

   typedef logic [ROWS-1:0][COLS-1:0][W-1:0] arr_t;

   arr_t   merged;
   arr_t   mem_q [FIFO_DEPTH];
   arr_t   replay_q;
   arr_t   head;
   logic [$clog2(FIFO_DEPTH)-1:0] rd_ptr_q, wr_ptr_q;
   logic [1:0] fill_q;
   state_e state_q, state_d;
   logic   push, pop, out_xfer;

   array_or_reduce #(.CH(CH), .ROWS(ROWS), .COLS(COLS), .W(W)) u_reduce (
      .in_data_i (in_data),
      .ch_mask_i (ch_mask),
      .merged_o  (merged)
   );

   always_comb begin
      head      = mem_q[rd_ptr_q];
      out_valid = !rst && ((state_q == REPLAY) || (fill_q != 2'd0));
      out_data  = '0;
      if (out_valid) begin
         out_data = (state_q == REPLAY) ? replay_q : head;
      end
      out_zero  = out_valid && (out_data == '0);
      // Entering REPLAY needs an empty buffer, so the entry cycle refuses new input.
      in_ready  = !rst && ((fill_q < 2'd2) || out_ready) && (state_q != REPLAY)
                  && !(replay && (fill_q == 2'd0) && (state_q != EMPTY_HIST));
      push      = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      pop       = out_xfer && (state_q != REPLAY);
      fill      = fill_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY_HIST: if (out_xfer)                      state_d = STREAM;
         STREAM:     if (replay && (fill_q == 2'd0))    state_d = REPLAY;
         REPLAY:     if (!replay)                       state_d = STREAM;
         default:                                       state_d = EMPTY_HIST;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q  <= EMPTY_HIST;
         fill_q   <= 2'd0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         replay_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_q + 2'(push) - 2'(pop);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (out_xfer) replay_q <= out_data;
      end
   end

   // NOTE: storage is not reset; fill_q gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= merged;
   end

`ifdef ARRAY_OR_MERGE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_in_cnt     <= 16'd0;
         stat_replay_cnt <= 16'd0;
         stat_zero_cnt   <= 16'd0;
      end else begin
         if (push)                            stat_in_cnt     <= stat_in_cnt + 16'd1;
         if (out_xfer && (state_q == REPLAY)) stat_replay_cnt <= stat_replay_cnt + 16'd1;
         if (out_xfer && out_zero)            stat_zero_cnt   <= stat_zero_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_array_or_merge_pipe.sv
// Directed bench for array_or_merge_pipe with a scoreboard of merged arrays.
// Statistics checks are included when ARRAY_OR_MERGE_STATS_EN is defined.
module tb_array_or_merge_pipe;

   localparam int CH = 4, ROWS = 2, COLS = 3, W = 3;
   typedef logic [ROWS-1:0][COLS-1:0][W-1:0]         arr_t;
   typedef logic [CH-1:0][ROWS-1:0][COLS-1:0][W-1:0] in_t;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, replay, out_valid, out_ready, out_zero;
   in_t           in_data;
   logic [CH-1:0] ch_mask;
   arr_t          out_data;
   logic [1:0]    fill;
`ifdef ARRAY_OR_MERGE_STATS_EN
   logic [15:0]   stat_in_cnt, stat_replay_cnt, stat_zero_cnt;
`endif

   int   total = 0;
   int   bad   = 0;
   arr_t sb [$];
   arr_t exp_q;
   arr_t a_exp;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   array_or_merge_pipe #(.CH(CH), .ROWS(ROWS), .COLS(COLS), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ch_mask   (ch_mask),
      .replay    (replay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .fill      (fill)
`ifdef ARRAY_OR_MERGE_STATS_EN
      ,
      .stat_in_cnt     (stat_in_cnt),
      .stat_replay_cnt (stat_replay_cnt),
      .stat_zero_cnt   (stat_zero_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic arr_t model(input in_t d, input logic [CH-1:0] m);
      arr_t res = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int ch = 0; ch < CH; ch++)
               if (m[ch]) res[r][c] = res[r][c] | d[ch][r][c];
      return res;
   endfunction

   task automatic rand_data();
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               in_data[ch][r][c] = W'($urandom_range(0, 7));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (fill != 2'd0 && n < 10) begin
         tick();
         n++;
      end
      @(negedge clk);
      chk({tag, "_fill"}, 32'(fill), 32'd0);
      chk({tag, "_sb_empty"}, sb.size(), 32'd0);
   endtask

   // Scoreboard: pop/compare on output transfers, push model result on input transfers.
   always @(negedge clk) begin
      if (!rst && mon_en) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_q = sb.pop_front();
               chk("sb_data", 32'(out_data), 32'(exp_q));
               chk("sb_zero", 32'(out_zero), 32'(exp_q == '0));
            end
         end
         if (in_valid && in_ready) sb.push_back(model(in_data, ch_mask));
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_mask = '0;
      replay = 1'b0; out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      tick(); tick();
      rst = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_fill", 32'(fill), 32'd0);

      // Single push, one-cycle latency
      tick();
      in_data = '0; in_data[0][0][0] = 3'b001; in_data[2][0][0] = 3'b100;
      ch_mask = 4'b0101; out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_fill", 32'(fill), 32'd1);
      chk("t1_word00", 32'(out_data[0][0]), 32'd5);
      tick();
      @(negedge clk);
      chk("t1_fill_after", 32'(fill), 32'd0);
      chk("t1_out_valid_after", 32'(out_valid), 32'd0);

      // Masked-out channels give an all-zero array
      tick();
      rand_data(); in_data[1][1][2] = 3'b111; ch_mask = 4'b0000;
      out_ready = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      chk("t2_out_zero", 32'(out_zero), 32'd1);
      chk("t2_out_data", 32'(out_data), 32'd0);
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("t2_fill", 32'(fill), 32'd0);

      // Backpressure: fill to 2, third push waits for a pop
      tick();
      out_ready = 1'b0; in_valid = 1'b1;
      rand_data(); ch_mask = 4'b0011;
      tick();
      rand_data(); ch_mask = 4'b1100;
      tick();
      rand_data(); ch_mask = 4'b1111;
      @(negedge clk);
      chk("t3_fill_full", 32'(fill), 32'd2);
      chk("t3_in_ready_full", 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_in_ready_pop", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_fill_keep", 32'(fill), 32'd2);
      drain("t3");

      // Replay the last delivered array
      tick();
      rand_data(); in_data[0][0][0] = 3'b111; ch_mask = 4'b0001;
      a_exp = model(in_data, ch_mask);
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      replay = 1'b1;
      @(negedge clk);
      chk("t4_entry_in_ready", 32'(in_ready), 32'd0);
      chk("t4_entry_out_valid", 32'(out_valid), 32'd0);
      tick();
      mon_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_rep_in_ready", 32'(in_ready), 32'd0);
         chk("t4_rep_out_valid", 32'(out_valid), 32'd1);
         chk("t4_rep_out_data", 32'(out_data), 32'(a_exp));
         chk("t4_rep_out_zero", 32'(out_zero), 32'd0);
         tick();
      end
      out_ready = 1'b0; replay = 1'b0;
      @(negedge clk);
      chk("t4_still_replay", 32'(out_valid), 32'd1);
      tick();
      mon_en = 1'b1;
      @(negedge clk);
      chk("t4_exit_in_ready", 32'(in_ready), 32'd1);
      chk("t4_exit_out_valid", 32'(out_valid), 32'd0);
`ifdef ARRAY_OR_MERGE_STATS_EN
      chk("t4_stat_replay", 32'(stat_replay_cnt), 32'd5);
`endif

      // Random streaming with random backpressure
      for (int i = 0; i < 24; i++) begin
         tick();
         in_valid  = 1'($urandom_range(0, 1));
         rand_data();
         ch_mask   = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      drain("t5");

      // Reset mid-operation with a full buffer
      tick();
      out_ready = 1'b0; in_valid = 1'b1; rand_data(); ch_mask = 4'b1001;
      tick();
      rand_data();
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_fill_full", 32'(fill), 32'd2);
      tick();
      rst = 1'b1; mon_en = 1'b0; sb.delete();
      @(negedge clk);
      chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      tick();
      rst = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      chk("t6_fill", 32'(fill), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_out_zero", 32'(out_zero), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
`ifdef ARRAY_OR_MERGE_STATS_EN
      chk("t6_stat_in", 32'(stat_in_cnt), 32'd0);
      chk("t6_stat_replay", 32'(stat_replay_cnt), 32'd0);
      chk("t6_stat_zero", 32'(stat_zero_cnt), 32'd0);
`endif

      // Replay request with no delivery history has no effect
      tick();
      replay = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("t7_in_ready", 32'(in_ready), 32'd1);
      chk("t7_out_valid_idle", 32'(out_valid), 32'd0);
      tick();
      rand_data(); ch_mask = 4'b1010; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t7_out_valid", 32'(out_valid), 32'd1);
      tick();
      replay = 1'b0;
      @(negedge clk);
      chk("t7_fill", 32'(fill), 32'd0);
      chk("t7_out_valid_after", 32'(out_valid), 32'd0);
      chk("t7_in_ready_after", 32'(in_ready), 32'd1);

`ifdef ARRAY_OR_MERGE_STATS_EN
      // Input counter wrap
      tick();
      rst = 1'b1; mon_en = 1'b0; sb.delete();
      tick();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ch_mask = 4'b0000;
      repeat (65535) tick();
      @(negedge clk);
      chk("t8_stat_in_max", 32'(stat_in_cnt), 32'hFFFF);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t8_stat_in_wrap", 32'(stat_in_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
